logic_unit_pipe: RTL

Parametrised, registered successor to the 1-bit eight-function logic selector. Applies one of the eight bitwise logic operations to WIDTH-bit operands under a valid/ready handshake with a single output register stage. Includes an accumulator mode in which the previous result replaces operand A, plus a transaction counter. It sits between an operand source and a result consumer in the lab datapath.

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_unit_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the ALU-family logic blocks.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOT_A = 3'b000;
  localparam op_t OP_NOT_B = 3'b001;
  localparam op_t OP_AND   = 3'b010;
  localparam op_t OP_NAND  = 3'b011;
  localparam op_t OP_XOR   = 3'b100;
  localparam op_t OP_XNOR  = 3'b101;
  localparam op_t OP_OR    = 3'b110;
  localparam op_t OP_NOR   = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational WIDTH-bit eight-function logic selector.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_opA,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result
);

  // Every opcode is legal, so each encoding maps to a defined result.
  always_comb begin
    o_result = '0;
    case (op_t'(i_op))
      OP_NOT_A: o_result = ~i_opA;
      OP_NOT_B: o_result = ~i_b;
      OP_AND:   o_result = i_opA & i_b;
      OP_NAND:  o_result = ~(i_opA & i_b);
      OP_XOR:   o_result = i_opA ^ i_b;
      OP_XNOR:  o_result = ~(i_opA ^ i_b);
      OP_OR:    o_result = i_opA | i_b;
      OP_NOR:   o_result = ~(i_opA | i_b);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, accumulator mode and
// an accepted-transaction counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic             r_outZero;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_opCount;

  logic             w_accept;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_result;

  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A same-cycle clear forces the accumulator operand to zero before use.
  assign w_opA = acc_mode ? (acc_clr ? '0 : r_acc) : a;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .i_opA    (w_opA),
    .i_b      (b),
    .i_op     (op),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outZero  <= 1'b0;
      r_opCount  <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= w_result;
      r_outZero  <= (w_result == '0);
      r_opCount  <= r_opCount + CNT_W'(1);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // An accumulating accept takes priority over a standalone clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept && acc_mode) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_zero  = r_outZero;
  assign acc       = r_acc;
  assign op_count  = r_opCount;

endmodule
